// File: rtl/riscv_ctrl_pkg.sv
// Shared opcodes, state encoding, datapath select codes and the decoded control bundle
// for the multicycle RISC-V controller.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_ctrl_e;

    typedef enum logic [1:0] {
        IMM_I = 2'b00,
        IMM_S = 2'b01,
        IMM_B = 2'b10,
        IMM_J = 2'b11
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_IMM = 2'b10,
        RES_PC4 = 2'b11
    } result_src_e;

    typedef enum logic [1:0] {
        PC_PLUS4 = 2'b00,
        PC_IMM   = 2'b01,
        PC_ALU   = 2'b10,
        PC_ZERO  = 2'b11
    } pc_src_e;

    typedef struct packed {
        logic        legal;
        logic        reg_write;
        logic        mem_write;
        logic        mem_access;
        logic        branch;
        logic        alu_src;
        alu_ctrl_e   alu_ctrl;
        imm_src_e    imm_src;
        result_src_e result_src;
        pc_src_e     pc_src;
    } ctrl_t;

    localparam ctrl_t CTRL_NONE = '{
        legal:      1'b0,
        reg_write:  1'b0,
        mem_write:  1'b0,
        mem_access: 1'b0,
        branch:     1'b0,
        alu_src:    1'b0,
        alu_ctrl:   ALU_ADD,
        imm_src:    IMM_I,
        result_src: RES_ALU,
        pc_src:     PC_PLUS4
    };

endpackage

// File: rtl/riscv_main_decoder.sv
// Combinational decode of opcode/funct3/funct7 into the control bundle.
// Illegal encodings yield CTRL_NONE so every select reads 00.
module riscv_main_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output ctrl_t      ctrl_o
);

    always_comb begin
        ctrl_o = CTRL_NONE;
        case (opcode_i)
            OP_R: begin
                ctrl_o.reg_write = 1'b1;
                if (funct7_i == 7'h00 || funct7_i == 7'h20) begin
                    case (funct3_i)
                        3'b000: begin
                            ctrl_o.legal    = 1'b1;
                            ctrl_o.alu_ctrl = funct7_i[5] ? ALU_SUB : ALU_ADD;
                        end
                        3'b111: begin
                            ctrl_o.legal    = 1'b1;
                            ctrl_o.alu_ctrl = ALU_AND;
                        end
                        3'b110: begin
                            ctrl_o.legal    = 1'b1;
                            ctrl_o.alu_ctrl = ALU_OR;
                        end
                        default: ;
                    endcase
                end
            end
            OP_I: begin
                ctrl_o.reg_write = 1'b1;
                ctrl_o.alu_src   = 1'b1;
                case (funct3_i)
                    3'b000: begin
                        ctrl_o.legal    = 1'b1;
                        ctrl_o.alu_ctrl = ALU_ADD;
                    end
                    3'b111: begin
                        ctrl_o.legal    = 1'b1;
                        ctrl_o.alu_ctrl = ALU_AND;
                    end
                    3'b110: begin
                        ctrl_o.legal    = 1'b1;
                        ctrl_o.alu_ctrl = ALU_OR;
                    end
                    default: ;
                endcase
            end
            OP_LW: begin
                ctrl_o.legal      = (funct3_i == 3'b010);
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_access = 1'b1;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.result_src = RES_MEM;
            end
            OP_SW: begin
                ctrl_o.legal      = (funct3_i == 3'b010);
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.mem_access = 1'b1;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.imm_src    = IMM_S;
            end
            OP_BEQ: begin
                ctrl_o.legal    = (funct3_i == 3'b000);
                ctrl_o.branch   = 1'b1;
                ctrl_o.imm_src  = IMM_B;
                ctrl_o.alu_ctrl = ALU_SUB;
            end
            OP_JAL: begin
                ctrl_o.legal      = 1'b1;
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.imm_src    = IMM_J;
                ctrl_o.result_src = RES_PC4;
                ctrl_o.pc_src     = PC_IMM;
            end
            OP_JALR: begin
                ctrl_o.legal      = (funct3_i == 3'b000);
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.alu_src    = 1'b1;
                ctrl_o.result_src = RES_PC4;
                ctrl_o.pc_src     = PC_ALU;
            end
            default: ;
        endcase
        // Partial fills above are discarded unless the encoding turned out legal.
        if (!ctrl_o.legal) begin
            ctrl_o = CTRL_NONE;
        end
    end

endmodule

// File: rtl/riscv_multicycle_ctrl.sv
// Multicycle control sequencer: fetch handshake, IR, FSM, trap flag, retire counter
// and WB-only strobe gating around the main decoder.
module riscv_multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned COUNT_W  = 32,
    parameter logic [31:0] IR_RESET = 32'h00000013
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [31:0]        instr_in,
    input  logic               zero,
    output logic               instr_ready,
    output logic [31:0]        intruccion,
    output logic               MemWrite,
    output logic               ALUSrc,
    output logic               RegWrite,
    output logic [1:0]         ALUControl,
    output logic [1:0]         ImmSrc,
    output logic [1:0]         ResultScr,
    output logic [1:0]         PCSrc,
    output logic               PCWrite,
    output logic               retire,
    output logic               trap,
    output logic [COUNT_W-1:0] retired_count
);

    state_e               state_q, state_d;
    logic [31:0]          ir_q, ir_d;
    logic                 trap_q, trap_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    ctrl_t                ctrl;
    logic                 sel_active;
    logic                 commit;

    riscv_main_decoder u_dec (
        .opcode_i (ir_q[6:0]),
        .funct3_i (ir_q[14:12]),
        .funct7_i (ir_q[31:25]),
        .ctrl_o   (ctrl)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            ir_q    <= IR_RESET;
            trap_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            trap_q  <= trap_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        trap_d  = trap_q;
        count_d = count_q;
        case (state_q)
            S_FETCH: begin
                if (instr_valid) begin
                    ir_d    = instr_in;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (ctrl.legal) begin
                    state_d = S_EXEC;
                end else begin
                    state_d = S_TRAP;
                    trap_d  = 1'b1;
                end
            end
            S_EXEC:  state_d = ctrl.mem_access ? S_MEM : S_WB;
            S_MEM:   state_d = S_WB;
            S_WB: begin
                state_d = S_FETCH;
                count_d = count_q + COUNT_W'(1);
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_FETCH;
        endcase
    end

    // Strobes are masked while rst is high so an aborted instruction never lands at the reset edge.
    always_comb begin
        sel_active = (state_q == S_DECODE) || (state_q == S_EXEC) ||
                     (state_q == S_MEM)    || (state_q == S_WB);
        commit     = (state_q == S_WB) && !rst;

        instr_ready = (state_q == S_FETCH) && !rst;
        intruccion  = ir_q;
        trap        = trap_q;

        ALUSrc     = 1'b0;
        ALUControl = 2'b00;
        ImmSrc     = 2'b00;
        ResultScr  = 2'b00;
        PCSrc      = 2'b00;
        if (sel_active) begin
            ALUSrc     = ctrl.alu_src;
            ALUControl = ctrl.alu_ctrl;
            ImmSrc     = ctrl.imm_src;
            ResultScr  = ctrl.result_src;
            if (ctrl.branch) begin
                PCSrc = zero ? PC_IMM : PC_PLUS4;
            end else begin
                PCSrc = ctrl.pc_src;
            end
        end

        RegWrite      = commit && ctrl.reg_write;
        MemWrite      = commit && ctrl.mem_write;
        PCWrite       = commit;
        retire        = commit;
        retired_count = count_q;
    end

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// Scoreboard bench: issued instructions push expected WB controls; a negedge monitor pops on retire.
module tb_riscv_multicycle_ctrl;

    typedef struct {
        logic [31:0] ir;
        logic        rw;
        logic        mw;
        logic        as;
        logic [1:0]  ac;
        logic [1:0]  is;
        logic [1:0]  rs;
        logic [1:0]  ps;
        int          cyc;
        logic [31:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic [31:0] instr_in;
    logic        zero;
    logic        instr_ready;
    logic [31:0] intruccion;
    logic        MemWrite, ALUSrc, RegWrite, PCWrite, retire, trap;
    logic [1:0]  ALUControl, ImmSrc, ResultScr, PCSrc;
    logic [31:0] retired_count;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] exp_count = 0;
    exp_t        sb[$];

    riscv_multicycle_ctrl #(.COUNT_W(32), .IR_RESET(32'h00000013)) dut (
        .clk           (clk),
        .rst           (rst),
        .instr_valid   (instr_valid),
        .instr_in      (instr_in),
        .zero          (zero),
        .instr_ready   (instr_ready),
        .intruccion    (intruccion),
        .MemWrite      (MemWrite),
        .ALUSrc        (ALUSrc),
        .RegWrite      (RegWrite),
        .ALUControl    (ALUControl),
        .ImmSrc        (ImmSrc),
        .ResultScr     (ResultScr),
        .PCSrc         (PCSrc),
        .PCWrite       (PCWrite),
        .retire        (retire),
        .trap          (trap),
        .retired_count (retired_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every commit must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            if (RegWrite || MemWrite || PCWrite || retire) begin
                errors++;
                $display("FAIL strobe_in_reset: got RegWrite=%b MemWrite=%b PCWrite=%b retire=%b expected 0",
                         RegWrite, MemWrite, PCWrite, retire);
            end
        end else if (retire) begin
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_commit: got retire=1 ir=0x%0h expected no commit", intruccion);
            end else begin
                e = sb.pop_front();
                chk("wb_cycle",   cyc,           e.cyc);
                chk("wb_ir",      intruccion,    e.ir);
                chk("RegWrite",   {31'd0, RegWrite}, {31'd0, e.rw});
                chk("MemWrite",   {31'd0, MemWrite}, {31'd0, e.mw});
                chk("PCWrite",    {31'd0, PCWrite},  32'd1);
                chk("ALUSrc",     {31'd0, ALUSrc},   {31'd0, e.as});
                chk("ALUControl", {30'd0, ALUControl}, {30'd0, e.ac});
                chk("ImmSrc",     {30'd0, ImmSrc},   {30'd0, e.is});
                chk("ResultScr",  {30'd0, ResultScr}, {30'd0, e.rs});
                chk("PCSrc",      {30'd0, PCSrc},    {30'd0, e.ps});
                chk("wb_count",   retired_count, e.cnt);
            end
        end else if (RegWrite || MemWrite || PCWrite) begin
            errors++;
            $display("FAIL stray_strobe: got RegWrite=%b MemWrite=%b PCWrite=%b expected 0 outside commit",
                     RegWrite, MemWrite, PCWrite);
        end
    end

    // Hand one instruction over; push an expectation only when it is meant to commit.
    task automatic issue(input logic [31:0] ins, input logic push,
                         input logic rw, input logic mw, input logic as,
                         input logic [1:0] ac, input logic [1:0] is,
                         input logic [1:0] rs, input logic [1:0] ps, input int lat);
        exp_t e;
        bit   ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (instr_ready) ok = 1;
        end
        if (!ok) begin
            errors++;
            $display("FAIL ready_timeout: got instr_ready=0 expected 1 within 20 cycles");
        end
        instr_in    = ins;
        instr_valid = 1'b1;
        if (push) begin
            e.ir = ins; e.rw = rw; e.mw = mw; e.as = as;
            e.ac = ac; e.is = is; e.rs = rs; e.ps = ps;
            e.cyc = cyc + lat;
            e.cnt = exp_count;
            exp_count = exp_count + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 instr_valid = 1'b0;
    endtask

    task automatic wait_fetch(input string name);
        bit ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            if (instr_ready) ok = 1;
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got instr_ready=0 expected 1 within 20 cycles", name);
        end
        chk({name, "_count"}, retired_count, exp_count);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        exp_count = 0;
    endtask

    initial begin
        rst = 1'b1; instr_valid = 1'b0; instr_in = '0; zero = 1'b0;
        do_reset();

        @(negedge clk);
        chk("rst_ready", {31'd0, instr_ready}, 32'd1);
        chk("rst_trap",  {31'd0, trap}, 32'd0);
        chk("rst_count", retired_count, 32'd0);
        chk("rst_ir",    intruccion, 32'h00000013);
        chk("rst_sel",   {24'd0, ALUSrc, ALUControl, ImmSrc, ResultScr, PCSrc[0]}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_ready",   {31'd0, instr_ready}, 32'd1);
            chk("idle_strobes", {28'd0, RegWrite, MemWrite, PCWrite, retire}, 32'd0);
            chk("idle_count",   retired_count, 32'd0);
        end

        issue(32'h002081B3, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3); wait_fetch("add");
        issue(32'h402081B3, 1, 1, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 3); wait_fetch("sub");
        issue(32'h0000A103, 1, 1, 0, 1, 2'b00, 2'b00, 2'b01, 2'b00, 4); wait_fetch("lw");
        issue(32'h0020A223, 1, 0, 1, 1, 2'b00, 2'b01, 2'b00, 2'b00, 4); wait_fetch("sw");
        zero = 1'b1;
        issue(32'h00000463, 1, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b01, 3); wait_fetch("beq_taken");
        zero = 1'b0;
        issue(32'h00000463, 1, 0, 0, 0, 2'b01, 2'b10, 2'b00, 2'b00, 3); wait_fetch("beq_not_taken");
        issue(32'h010000EF, 1, 1, 0, 0, 2'b00, 2'b11, 2'b11, 2'b01, 3); wait_fetch("jal");
        issue(32'h00008067, 1, 1, 0, 1, 2'b00, 2'b00, 2'b11, 2'b10, 3); wait_fetch("jalr");
        issue(32'h0070F093, 1, 1, 0, 1, 2'b10, 2'b00, 2'b00, 2'b00, 3); wait_fetch("andi");
        issue(32'h0020E1B3, 1, 1, 0, 0, 2'b11, 2'b00, 2'b00, 2'b00, 3); wait_fetch("or");

        // lw aborted by reset held across its WB cycle
        issue(32'h0000A103, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("wbrst_strobes", {28'd0, RegWrite, MemWrite, PCWrite, retire}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_count = 0;
        @(negedge clk);
        chk("wbrst_ready", {31'd0, instr_ready}, 32'd1);
        chk("wbrst_count", retired_count, 32'd0);

        // sw aborted by reset asserted in MEM
        issue(32'h002081B3, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3); wait_fetch("add_pre_sw");
        issue(32'h0020A223, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 4);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("memrst_memwrite", {31'd0, MemWrite}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_count = 0;
        @(negedge clk);
        chk("memrst_ready", {31'd0, instr_ready}, 32'd1);
        chk("memrst_count", retired_count, 32'd0);
        repeat (5) @(negedge clk);
        chk("memrst_no_commit", retired_count, 32'd0);

        // illegal word traps and stays trapped despite instr_valid
        issue(32'h002081B3, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3); wait_fetch("add_pre_trap");
        issue(32'h00000000, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3);
        @(posedge clk);
        #1 instr_valid = 1'b1; instr_in = 32'h002081B3;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("trap_flag",  {31'd0, trap}, 32'd1);
            chk("trap_ready", {31'd0, instr_ready}, 32'd0);
            chk("trap_count", retired_count, 32'd1);
        end
        instr_valid = 1'b0;
        do_reset();
        @(negedge clk);
        chk("trap_rst_flag",  {31'd0, trap}, 32'd0);
        chk("trap_rst_ready", {31'd0, instr_ready}, 32'd1);

        // a malformed funct7 on an R-type also traps
        issue(32'h022081B3, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 3);
        repeat (2) @(negedge clk);
        chk("badf7_trap", {31'd0, trap}, 32'd1);
        do_reset();

        chk("scoreboard_drained", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200000 time units");
        $fatal(1, "timeout");
    end

endmodule
